// File: rtl/systolic_pkg.sv
// Shared defaults and types for the systolic array datapath and its operand feeder.
package systolic_pkg;

  localparam int unsigned BITS_AB_DEF = 8;
  localparam int unsigned BITS_C_DEF  = 32;
  localparam int unsigned DIM_DEF     = 8;
  localparam int unsigned FEED_CYCLES = 3 * DIM_DEF - 2;

  typedef logic signed [BITS_AB_DEF-1:0] operand_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} feeder_state_t;

  function automatic int unsigned feed_cycles(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Load/start handshake and skewed operand bus between controller, feeder and array.
interface systolic_feeder_if #(
  parameter int unsigned BITS_AB = systolic_pkg::BITS_AB_DEF,
  parameter int unsigned DIM     = systolic_pkg::DIM_DEF
);
  localparam int unsigned ROWBITS = $clog2(DIM);

  logic                           wr_valid;
  logic                           wr_ready;
  logic [ROWBITS-1:0]             wr_row;
  logic [DIM-1:0][BITS_AB-1:0]    wr_a;
  logic [DIM-1:0][BITS_AB-1:0]    wr_b;
  logic                           start;
  logic                           busy;
  logic                           done;
  logic                           en;
  logic [DIM-1:0][BITS_AB-1:0]    A;
  logic [DIM-1:0][BITS_AB-1:0]    B;

  modport master (
    output wr_valid, wr_row, wr_a, wr_b, start,
    input  wr_ready, busy, done, en, A, B
  );

  modport slave (
    input  wr_valid, wr_row, wr_a, wr_b, start,
    output wr_ready, busy, done, en, A, B
  );

endinterface

// File: rtl/skew_lane.sv
// One diagonal lane: picks element (cnt - LANE) of a row/column vector, zero when outside it.
module skew_lane #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned CNTW    = 5,
  parameter int unsigned LANE    = 0
) (
  input  logic [CNTW-1:0]            cnt,
  input  logic [DIM-1:0][BITS_AB-1:0] vec,
  output logic [BITS_AB-1:0]         q
);

  logic [31:0] idx;

  // cnt < LANE wraps idx to a huge value, so it never matches a valid slot.
  always_comb begin
    idx = 32'(cnt) - LANE;
    q   = '0;
    for (int k = 0; k < int'(DIM); k++) begin
      if (idx == 32'(k)) q = vec[k];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Stages A/B matrices and feeds them diagonally skewed into systolic_array for 3*DIM-2 cycles.
// Define FEEDER_B_COLMAJOR_EN to load B one column per write instead of one row.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEF,
  parameter int unsigned DIM     = DIM_DEF
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);

  localparam int unsigned ROWBITS = $clog2(DIM);
  localparam int unsigned NCYC    = feed_cycles(DIM);
  localparam int unsigned CNTW    = $clog2(NCYC);

  typedef logic [DIM-1:0][BITS_AB-1:0] vec_t;

  feeder_state_t   state_q;
  logic [CNTW-1:0] cnt_q, cnt_nxt;
  vec_t            reg_a_q [DIM];
  vec_t            reg_b_q [DIM];
  vec_t            reg_a_d [DIM];
  vec_t            reg_b_d [DIM];
  vec_t            b_col   [DIM];
  vec_t            lane_a, lane_b;
  vec_t            a_q, b_q;
  logic            en_q, busy_q, done_q;
  logic            wr_en;

  assign bus.wr_ready = (state_q == IDLE);
  assign wr_en = bus.wr_valid && bus.wr_ready && (32'(bus.wr_row) < DIM);

  // Lanes look at next-state storage so a write coinciding with start feeds from t=0.
  always_comb begin
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    if (wr_en) begin
      reg_a_d[bus.wr_row] = bus.wr_a;
`ifdef FEEDER_B_COLMAJOR_EN
      for (int j = 0; j < int'(DIM); j++) reg_b_d[j][bus.wr_row] = bus.wr_b[j];
`else
      reg_b_d[bus.wr_row] = bus.wr_b;
`endif
    end
  end

  always_ff @(posedge clk) begin
    reg_a_q <= reg_a_d;
    reg_b_q <= reg_b_d;
  end

  always_comb begin
    for (int j = 0; j < int'(DIM); j++) begin
      for (int k = 0; k < int'(DIM); k++) b_col[j][k] = reg_b_d[k][j];
    end
  end

  assign cnt_nxt = (state_q == IDLE) ? '0 : cnt_q + CNTW'(1);

  for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
    skew_lane #(.BITS_AB(BITS_AB), .DIM(DIM), .CNTW(CNTW), .LANE(i)) u_lane_a (
      .cnt (cnt_nxt),
      .vec (reg_a_d[i]),
      .q   (lane_a[i])
    );
    skew_lane #(.BITS_AB(BITS_AB), .DIM(DIM), .CNTW(CNTW), .LANE(i)) u_lane_b (
      .cnt (cnt_nxt),
      .vec (b_col[i]),
      .q   (lane_b[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            a_q     <= lane_a;
            b_q     <= lane_b;
          end
        end
        RUN: begin
          if (cnt_q == CNTW'(NCYC - 1)) begin
            state_q <= DONE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
          end else begin
            cnt_q <= cnt_nxt;
            a_q   <= lane_a;
            b_q   <= lane_b;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.A    = a_q;
  assign bus.B    = b_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: expected skewed vectors are queued at start, a
// monitor pops one per enabled cycle. Define FEEDER_B_COLMAJOR_EN to load B by column.
module tb_systolic_feeder;

  typedef logic [7:0][7:0] vec_t;
  typedef struct packed {
    vec_t a;
    vec_t b;
  } feed_t;

  logic clk;
  logic rst;

  systolic_feeder_if #(.BITS_AB(8), .DIM(8)) bus ();

  systolic_feeder #(.BITS_AB(8), .DIM(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int en_total = 0;
  int done_total = 0;
  logic en_prev = 1'b0;
  int mon_t = 0;
  feed_t exp_q[$];
  logic [7:0] mA [8][8];
  logic [7:0] mB [8][8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic feed_t exp_at(input int t);
    feed_t e;
    for (int i = 0; i < 8; i++) begin
      int k = t - i;
      e.a[i] = (k >= 0 && k < 8) ? mA[i][k] : 8'h00;
      e.b[i] = (k >= 0 && k < 8) ? mB[k][i] : 8'h00;
    end
    return e;
  endfunction

  // Monitor: every enabled cycle must match the next queued vector.
  initial begin
    feed_t e;
    forever begin
      @(negedge clk);
      if (bus.en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL en_unexpected actual=en high required=no enable");
        end else begin
          bad = bad;
          e = exp_q.pop_front();
          chk($sformatf("feed_a t=%0d", mon_t), bus.A, e.a);
          chk($sformatf("feed_b t=%0d", mon_t), bus.B, e.b);
        end
        mon_t++;
        en_total++;
      end else begin
        mon_t = 0;
        chk("idle_a_zero", bus.A, 64'h0);
        chk("idle_b_zero", bus.B, 64'h0);
      end
      if (bus.done) begin
        done_total++;
        chk("done_after_last_en", 64'(en_prev & ~bus.en), 64'h1);
      end
      en_prev = bus.en;
    end
  end

  task automatic load_row(input int k);
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'(k);
    for (int j = 0; j < 8; j++) begin
      bus.wr_a[j] = mA[k][j];
`ifdef FEEDER_B_COLMAJOR_EN
      bus.wr_b[j] = mB[j][k];
`else
      bus.wr_b[j] = mB[k][j];
`endif
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // hand: 1 = identity/ramp spot checks, 2 = row-0-all-7 spot checks.
  task automatic run_feed(input int hand, input int restart_at, input int rst_at,
                          input int wr_at);
    int exp_len;
    int exp_done;
    int en0;
    int done0;
    exp_len  = (rst_at >= 0) ? rst_at + 1 : 22;
    exp_done = (rst_at >= 0) ? 0 : 1;
    for (int t = 0; t < exp_len; t++) exp_q.push_back(exp_at(t));
    en0   = en_total;
    done0 = done_total;
    bus.start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      if (hand == 1 && t == 0) begin
        chk("t0_A", bus.A, 64'h0000_0000_0000_0001);
        chk("t0_B", bus.B, 64'h0);
      end
      if (hand == 1 && t == 9) begin
        chk("t9_A2", 64'(bus.A[2]), 64'd0);
        chk("t9_B2", 64'(bus.B[2]), 64'd58);
      end
      if (hand == 2 && t == 0) begin
        chk("t0_A0_seven", 64'(bus.A[0]), 64'd7);
        chk("t0_B0_seven", 64'(bus.B[0]), 64'd7);
      end
      if (t == 3) begin
        chk("run_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("run_busy", 64'(bus.busy), 64'd1);
      end
      bus.start    = (t == restart_at);
      rst          = (t == rst_at);
      bus.wr_valid = (t == wr_at);
      bus.wr_row   = 3'd1;
      bus.wr_a     = {8{8'h55}};
      bus.wr_b     = {8{8'haa}};
      @(negedge clk);
    end
    bus.start    = 1'b0;
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    chk("en_len", 64'(en_total - en0), 64'(exp_len));
    chk("done_count", 64'(done_total - done0), 64'(exp_done));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_wr_ready", 64'(bus.wr_ready), 64'd1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_row   = '0;
    bus.wr_a     = '0;
    bus.wr_b     = '0;
    bus.start    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        mA[k][j] = (k == j) ? 8'd1 : 8'd0;
        mB[k][j] = 8'(k * 8 + j);
      end
    end

    repeat (5) begin
      @(negedge clk);
      chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
      chk("rst_en", 64'(bus.en), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) load_row(k);

    // Basic run; a write attempted mid-run must be ignored.
    run_feed(1, -1, -1, 3);
    // start re-asserted during the run is dropped.
    run_feed(0, 5, -1, -1);
    // Reset at t=10 aborts without done; storage survives for the rerun.
    run_feed(0, -1, 10, -1);
    run_feed(1, -1, -1, -1);

    // Write and start in the same cycle.
    for (int j = 0; j < 8; j++) begin
      mA[0][j] = 8'd7;
`ifdef FEEDER_B_COLMAJOR_EN
      mB[j][0] = 8'd7;
`else
      mB[0][j] = 8'd7;
`endif
    end
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd0;
    bus.wr_a     = {8{8'd7}};
    bus.wr_b     = {8{8'd7}};
    run_feed(2, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
